// File: rtl/fp32_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fp32_frame_sequencer_if
// Brief    : UART-side handshake and status bundle for fp32_frame_sequencer.
//            master = sequencer side, slave = UART / environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface fp32_frame_sequencer_if;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [31:0] word_out;
  logic        word_valid;
  logic        frame_done;
  logic        rx_timeout;
  logic        overrun;
  logic        tx_err;
  logic [2:0]  state;

  modport master (
    input  rx_done, rx_data, tx_busy,
    output tx_start, tx_data, word_out, word_valid, frame_done,
           rx_timeout, overrun, tx_err, state
  );

  modport slave (
    output rx_done, rx_data, tx_busy,
    input  tx_start, tx_data, word_out, word_valid, frame_done,
           rx_timeout, overrun, tx_err, state
  );
endinterface
`default_nettype wire

// File: rtl/fp32_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fp32_frame_sequencer
// Brief    : Captures one frame of UART bytes, emits little-endian fp32 words
//            every 4 bytes, then replays the frame through the UART TX using
//            a start-pulse / busy handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_frame_sequencer #(
  parameter int FRAME_BYTES  = 96,
  parameter int RX_TIMEOUT   = 1_000_000,
  parameter int TX_ACK_LIMIT = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  fp32_frame_sequencer_if.master bus
);

  localparam int CW = $clog2(FRAME_BYTES);
  localparam int IW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam int AW = (TX_ACK_LIMIT > 1) ? $clog2(TX_ACK_LIMIT) : 1;
  localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_BYTES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(RX_TIMEOUT - 1);
  localparam logic [AW-1:0] ACK_LAST  = AW'(TX_ACK_LIMIT - 1);

  typedef enum logic [2:0] {
    RECV       = 3'd0,
    TX_LOAD    = 3'd1,
    TX_START   = 3'd2,
    TX_WAIT_HI = 3'd3,
    TX_WAIT_LO = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          rx_prev_q, rx_prev_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [AW-1:0] ack_q, ack_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [31:0]   word_out_q, word_out_d;
  logic          word_valid_q, word_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          rx_timeout_q, rx_timeout_d;
  logic          overrun_q, overrun_d;
  logic          tx_err_q, tx_err_d;
  logic          byte_sent;
  logic          rx_edge;

  // Frame storage; contents are meaningless until written, so no reset.
  logic [7:0]    frame_buf [FRAME_BYTES];

  // rx_prev resets high, so a level already high at reset release is not a byte.
  assign rx_edge = bus.rx_done & ~rx_prev_q;

  // Next-state and next-output computation for the receive/transmit sequencer.
  always_comb begin
    state_d      = state_q;
    rx_prev_d    = bus.rx_done;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    idle_d       = idle_q;
    ack_d        = ack_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    word_out_d   = word_out_q;
    word_valid_d = 1'b0;
    frame_done_d = 1'b0;
    rx_timeout_d = 1'b0;
    overrun_d    = overrun_q;
    tx_err_d     = tx_err_q;
    byte_sent    = 1'b0;

    // Bytes arriving while transmitting are dropped, only flagged.
    if (rx_edge && (state_q != RECV)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      RECV: begin
        if (rx_edge) begin
          idle_d = '0;
          if (wr_cnt_q[1:0] == 2'd3) begin
            word_out_d   = {bus.rx_data,
                            frame_buf[wr_cnt_q - CW'(1)],
                            frame_buf[wr_cnt_q - CW'(2)],
                            frame_buf[wr_cnt_q - CW'(3)]};
            word_valid_d = 1'b1;
          end
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            state_d  = TX_LOAD;
          end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end else if (wr_cnt_q != '0) begin
          // A partial frame that goes quiet too long is abandoned.
          if (idle_q == IDLE_LAST) begin
            idle_d       = '0;
            wr_cnt_d     = '0;
            rx_timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end else begin
          idle_d = '0;
        end
      end
      TX_LOAD: begin
        if (!bus.tx_busy) begin
          tx_data_d  = frame_buf[rd_cnt_q];
          tx_start_d = 1'b1;
          state_d    = TX_START;
        end
      end
      TX_START: begin
        ack_d   = '0;
        state_d = TX_WAIT_HI;
      end
      TX_WAIT_HI: begin
        if (bus.tx_busy) begin
          state_d = TX_WAIT_LO;
        end else if (ack_q == ACK_LAST) begin
          // Transmitter never acknowledged: flag it and move on anyway.
          tx_err_d  = 1'b1;
          byte_sent = 1'b1;
        end else begin
          ack_d = ack_q + AW'(1);
        end
      end
      TX_WAIT_LO: begin
        if (!bus.tx_busy) begin
          byte_sent = 1'b1;
        end
      end
      default: state_d = RECV;
    endcase

    // Common exit once a byte is considered transmitted.
    if (byte_sent) begin
      if (rd_cnt_q == LAST_IDX) begin
        frame_done_d = 1'b1;
        rd_cnt_d     = '0;
        state_d      = RECV;
      end else begin
        rd_cnt_d = rd_cnt_q + CW'(1);
        state_d  = TX_LOAD;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RECV;
      rx_prev_q    <= 1'b1;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      idle_q       <= '0;
      ack_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      rx_timeout_q <= 1'b0;
      overrun_q    <= 1'b0;
      tx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_prev_q    <= rx_prev_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      idle_q       <= idle_d;
      ack_q        <= ack_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      frame_done_q <= frame_done_d;
      rx_timeout_q <= rx_timeout_d;
      overrun_q    <= overrun_d;
      tx_err_q     <= tx_err_d;
    end
  end

  // Frame buffer write on each accepted byte.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == RECV) && rx_edge) begin
      frame_buf[wr_cnt_q] <= bus.rx_data;
    end
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.word_out   = word_out_q;
  assign bus.word_valid = word_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.rx_timeout = rx_timeout_q;
  assign bus.overrun    = overrun_q;
  assign bus.tx_err     = tx_err_q;
  assign bus.state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_frame_sequencer
// Brief    : Self-checking bench for fp32_frame_sequencer with a UART TX
//            responder and a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_frame_sequencer;
  localparam int FB       = 96;
  localparam int TO       = 50;
  localparam int ACK      = 16;
  localparam int BUSY_LEN = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp32_frame_sequencer_if bus();

  fp32_frame_sequencer #(
    .FRAME_BYTES (FB),
    .RX_TIMEOUT  (TO),
    .TX_ACK_LIMIT(ACK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]  fr [FB];
  logic [31:0] words [$];
  logic [7:0]  tx_seen [$];
  int edge_cyc, tx_mode, busy_left, done_cnt, to_cnt, to_cyc, err_cyc;
  int first_start_cyc, start_bad;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer plus UART TX responder (0: busy 1 cycle after start for
  // BUSY_LEN cycles, 1: never busy, 2: always busy).
  always @(negedge clk) begin
    if (bus.word_valid) words.push_back(bus.word_out);
    if (bus.frame_done) done_cnt++;
    if (bus.rx_timeout) begin to_cnt++; to_cyc = cyc; end
    if (bus.tx_err && err_cyc < 0) err_cyc = cyc;
    if (bus.tx_start) begin
      tx_seen.push_back(bus.tx_data);
      if (first_start_cyc < 0) first_start_cyc = cyc;
      if (bus.state != 3'd2) start_bad++;
    end
    if (tx_mode == 2) bus.tx_busy = 1'b1;
    else if (tx_mode == 1) bus.tx_busy = 1'b0;
    else if (busy_left > 0) begin bus.tx_busy = 1'b1; busy_left--; end
    else bus.tx_busy = 1'b0;
    if (bus.tx_start && tx_mode == 0) busy_left = BUSY_LEN;
  end

  // Reference model: word i is bytes 4i..4i+3 of the frame, first byte lowest.
  function automatic logic [31:0] exp_word(int i);
    return {fr[4*i+3], fr[4*i+2], fr[4*i+1], fr[4*i]};
  endfunction

  task automatic clear_log();
    words.delete(); tx_seen.delete();
    done_cnt = 0; to_cnt = 0; to_cyc = -1; err_cyc = -1;
    first_start_cyc = -1; start_bad = 0; busy_left = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; bus.rx_done = 1'b0; bus.rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
  endtask

  // Called just after a clock edge; rx_done high 2 cycles, next byte 'gap' later.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data = b; bus.rx_done = 1'b1; edge_cyc = cyc;
    repeat (2) @(posedge clk);
    #1 bus.rx_done = 1'b0;
    repeat (gap - 2) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit rand_gap);
    for (int i = 0; i < FB; i++)
      send_byte(fr[i], rand_gap ? int'($urandom_range(3, 30)) : 10);
  endtask

  task automatic fill_random();
    for (int i = 0; i < FB; i++) fr[i] = 8'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(posedge clk); n++; end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    checks++; if ({bus.tx_data, bus.word_out} !== 40'h0) begin errors++; $display("FAIL reset_data: got %h/%h expected 00/00000000", bus.tx_data, bus.word_out); end
    checks++; if ({bus.tx_start, bus.word_valid, bus.frame_done, bus.rx_timeout, bus.overrun, bus.tx_err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000", {bus.tx_start, bus.word_valid, bus.frame_done, bus.rx_timeout, bus.overrun, bus.tx_err}); end
  endtask

  task automatic test_full_frame();
    int nbad = 0;
    logic [31:0] w0, wl;
    apply_reset(); tx_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < FB; i++) fr[i] = 8'(i);
    send_frame(1'b0);
    wait_done(FB * 50);
    w0 = (words.size() > 0) ? words[0] : 32'hx;
    wl = (words.size() > 0) ? words[words.size()-1] : 32'hx;
    checks++; if (words.size() != FB/4) begin errors++; $display("FAIL full_word_count: got %0d expected %0d", words.size(), FB/4); end
    checks++; if (w0 !== 32'h03020100) begin errors++; $display("FAIL full_first_word: got %h expected 03020100", w0); end
    checks++; if (wl !== 32'h5F5E5D5C) begin errors++; $display("FAIL full_last_word: got %h expected 5f5e5d5c", wl); end
    for (int i = 0; i < FB; i++) if (i >= tx_seen.size() || tx_seen[i] !== 8'(i)) nbad++;
    checks++; if (tx_seen.size() != FB || nbad != 0) begin errors++; $display("FAIL full_tx_bytes: got %0d starts %0d wrong expected %0d starts 0 wrong", tx_seen.size(), nbad, FB); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_frame_done: got %0d expected 1", done_cnt); end
    checks++; if (start_bad != 0) begin errors++; $display("FAIL full_start_state: got %0d starts outside TX_START expected 0", start_bad); end
    checks++; if (bus.overrun !== 1'b0 || to_cnt != 0) begin errors++; $display("FAIL full_no_err: got overrun %b timeouts %0d expected 0 0", bus.overrun, to_cnt); end
  endtask

  task automatic test_overrun();
    int nbad = 0, n = 0;
    apply_reset(); tx_mode = 0;
    @(posedge clk); #1;
    fill_random();
    send_frame(1'b1);
    while (bus.state !== 3'd4 && n < 200) begin @(negedge clk); n++; end
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL ovr_reach_wait_lo: got state %0d expected 4", bus.state); end
    bus.rx_data = 8'($urandom); bus.rx_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.rx_done = 1'b0;
    @(negedge clk);
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", bus.overrun); end
    wait_done(FB * 50);
    for (int i = 0; i < FB; i++) if (i >= tx_seen.size() || tx_seen[i] !== fr[i]) nbad++;
    checks++; if (tx_seen.size() != FB || nbad != 0 || done_cnt != 1) begin errors++; $display("FAIL ovr_tx_seq: got %0d starts %0d wrong %0d done expected %0d 0 1", tx_seen.size(), nbad, done_cnt, FB); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", bus.overrun); end
    clear_log(); fill_random(); nbad = 0;
    send_frame(1'b1);
    wait_done(FB * 50);
    for (int i = 0; i < FB/4; i++) if (i >= words.size() || words[i] !== exp_word(i)) nbad++;
    for (int i = 0; i < FB; i++) if (i >= tx_seen.size() || tx_seen[i] !== fr[i]) nbad++;
    checks++; if (words.size() != FB/4 || tx_seen.size() != FB || nbad != 0) begin
      errors++; $display("FAIL ovr_next_frame: got %0d words %0d starts %0d wrong expected %0d %0d 0", words.size(), tx_seen.size(), nbad, FB/4, FB); end
  endtask

  task automatic test_timeout();
    logic [7:0] part [5];
    logic [31:0] w0;
    int nbad = 0;
    apply_reset(); tx_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      part[i] = 8'($urandom);
      send_byte(part[i], (i == 4) ? 10 : int'($urandom_range(3, 30)));
    end
    repeat (60) @(posedge clk);
    #1;
    checks++; if (to_cnt != 1) begin errors++; $display("FAIL to_count: got %0d expected 1", to_cnt); end
    // Capture clock ends the edge cycle; idle counter runs 0..TO-1 from the
    // next cycle and the registered pulse shows TO cycles after the capture.
    checks++; if (to_cyc - edge_cyc != TO + 1) begin errors++; $display("FAIL to_latency: got %0d expected %0d", to_cyc - edge_cyc, TO + 1); end
    w0 = (words.size() > 0) ? words[0] : 32'hx;
    checks++; if (words.size() != 1 || w0 !== {part[3], part[2], part[1], part[0]}) begin
      errors++; $display("FAIL to_partial_word: got %0d words first %h expected 1 %h", words.size(), w0, {part[3], part[2], part[1], part[0]}); end
    clear_log(); fill_random();
    send_frame(1'b1);
    wait_done(FB * 50);
    for (int i = 0; i < FB/4; i++) if (i >= words.size() || words[i] !== exp_word(i)) nbad++;
    for (int i = 0; i < FB; i++) if (i >= tx_seen.size() || tx_seen[i] !== fr[i]) nbad++;
    checks++; if (words.size() != FB/4 || tx_seen.size() != FB || nbad != 0 || to_cnt != 0) begin
      errors++; $display("FAIL to_next_frame: got %0d words %0d starts %0d wrong %0d timeouts expected %0d %0d 0 0", words.size(), tx_seen.size(), nbad, to_cnt, FB/4, FB); end
  endtask

  task automatic test_tx_stall();
    int stall_bad = 0, nbad = 0, m;
    apply_reset(); tx_mode = 2;
    @(posedge clk); #1;
    fill_random();
    send_frame(1'b1);
    repeat (12) begin
      @(negedge clk);
      if (bus.state !== 3'd1 || bus.tx_start !== 1'b0) stall_bad++;
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", stall_bad); end
    @(posedge clk); #1;
    m = cyc; tx_mode = 0;
    wait_done(FB * 50);
    // busy first reads 0 in cycle m; TX_START (and tx_start) follows next cycle.
    checks++; if (first_start_cyc != m + 1) begin errors++; $display("FAIL stall_release: got start at +%0d expected +1", first_start_cyc - m); end
    for (int i = 0; i < FB; i++) if (i >= tx_seen.size() || tx_seen[i] !== fr[i]) nbad++;
    checks++; if (tx_seen.size() != FB || nbad != 0 || done_cnt != 1) begin errors++; $display("FAIL stall_tx_seq: got %0d starts %0d wrong %0d done expected %0d 0 1", tx_seen.size(), nbad, done_cnt, FB); end
  endtask

  task automatic test_no_ack();
    int nbad = 0;
    apply_reset(); tx_mode = 1;
    @(posedge clk); #1;
    fill_random();
    send_frame(1'b1);
    wait_done(FB * 50);
    // TX_START at s, ACK cycles of TX_WAIT_HI at s+1..s+ACK, flag visible after.
    checks++; if (err_cyc < 0 || err_cyc != first_start_cyc + ACK + 1) begin errors++; $display("FAIL noack_err_time: got %0d expected %0d", err_cyc - first_start_cyc, ACK + 1); end
    for (int i = 0; i < FB; i++) if (i >= tx_seen.size() || tx_seen[i] !== fr[i]) nbad++;
    checks++; if (tx_seen.size() != FB || nbad != 0) begin errors++; $display("FAIL noack_tx_seq: got %0d starts %0d wrong expected %0d 0", tx_seen.size(), nbad, FB); end
    checks++; if (done_cnt != 1 || bus.tx_err !== 1'b1) begin errors++; $display("FAIL noack_done: got done %0d err %b expected 1 1", done_cnt, bus.tx_err); end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] nb [4];
    logic [31:0] w0;
    int n = 0;
    apply_reset(); tx_mode = 0;
    @(posedge clk); #1;
    fill_random();
    send_frame(1'b1);
    while (tx_seen.size() < 41 && n < FB * 50) begin @(posedge clk); n++; end
    #1;
    checks++; if (tx_seen.size() < 41) begin errors++; $display("FAIL rst_reach_byte40: got %0d starts expected 41", tx_seen.size()); end
    rst = 1'b1; bus.rx_done = 1'b1; bus.rx_data = 8'($urandom);
    @(posedge clk); #1;
    rst = 1'b0; clear_log();
    @(negedge clk);
    checks++; if (bus.state !== 3'd0 || {bus.tx_data, bus.word_out} !== 40'h0) begin errors++; $display("FAIL rst_mid_values: got state %0d data %h/%h expected 0 00/00000000", bus.state, bus.tx_data, bus.word_out); end
    checks++; if ({bus.tx_start, bus.word_valid, bus.frame_done, bus.rx_timeout, bus.overrun, bus.tx_err} !== 6'b0) begin
      errors++; $display("FAIL rst_mid_flags: got %b expected 000000", {bus.tx_start, bus.word_valid, bus.frame_done, bus.rx_timeout, bus.overrun, bus.tx_err}); end
    repeat (5) @(posedge clk);
    #1 bus.rx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin nb[i] = 8'($urandom); send_byte(nb[i], 8); end
    w0 = (words.size() > 0) ? words[0] : 32'hx;
    checks++; if (words.size() != 1 || w0 !== {nb[3], nb[2], nb[1], nb[0]}) begin
      errors++; $display("FAIL rst_no_capture: got %0d words first %h expected 1 %h", words.size(), w0, {nb[3], nb[2], nb[1], nb[0]}); end
    checks++; if (tx_seen.size() != 0 || done_cnt != 0 || bus.state !== 3'd0) begin
      errors++; $display("FAIL rst_tx_abort: got %0d starts %0d done state %0d expected 0 0 0", tx_seen.size(), done_cnt, bus.state); end
  endtask

  initial begin
    rst = 1'b1; bus.rx_done = 1'b0; bus.rx_data = 8'h00; tx_mode = 0;
    clear_log();
    test_reset();
    test_full_frame();
    test_overrun();
    test_timeout();
    test_tx_stall();
    test_no_ack();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
